// File: rtl/ptype_rr_arb.sv
// ptype_rr_arb: round-robin arbiter feeding a single-entry output register.
// NUM_REQ requesters share one typed datapath; the held beat carries the
// index of the requester that supplied it.
// Optional feature: define PTYPE_RR_ARB_LOCK_EN to add req_lock. A locked
// accept keeps the grant on that requester until it sends an unlocked beat.
//
// state | meaning
// EMPTY | output register holds no beat, out_valid=0
// FULL  | output register holds a beat, out_valid=1
module ptype_rr_arb #(
   parameter int  NUM_REQ = 4,
   parameter int  WIDTH   = 8,
   parameter type TYPE_T  = logic [WIDTH-1:0]
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  TYPE_T                        req_data [NUM_REQ],
`ifdef PTYPE_RR_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]           req_lock,
`endif
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         out_valid,
   output TYPE_T                        out_data,
   output logic [$clog2(NUM_REQ)-1:0]   out_id,
   input  logic                         out_ready
);

   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t          state;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] win;
   logic [ID_W-1:0] cand;
   logic [ID_W-1:0] ptr_next;
   logic            win_found;
   logic            can_load;
   int              idx_c;

`ifdef PTYPE_RR_ARB_LOCK_EN
   logic            lock_active;
   logic [ID_W-1:0] lock_id;
`endif

   assign out_valid = (state == FULL);
   assign can_load  = (state == EMPTY) | (out_ready & out_valid);
   // Explicit wrap so non-power-of-2 NUM_REQ never lands on an unused index.
   assign ptr_next  = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);

   // Search for the first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win       = '0;
      idx_c     = 0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_c = int'(rr_ptr) + i;
         if (idx_c >= NUM_REQ) idx_c = idx_c - NUM_REQ;
         cand = ID_W'(idx_c);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win       = cand;
         end
      end
`ifdef PTYPE_RR_ARB_LOCK_EN
      // A held lock pins the grant even when the owner is idle.
      if (lock_active) begin
         win       = lock_id;
         win_found = req_valid[lock_id];
      end
`endif
   end

   // One-hot accept towards the winner; forced low while reset is asserted.
   always_comb begin
      req_ready = '0;
      if (rst_n && can_load && win_found) req_ready[win] = 1'b1;
   end

   // Output register, FSM and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         out_data <= '0;
         out_id   <= '0;
         rr_ptr   <= '0;
`ifdef PTYPE_RR_ARB_LOCK_EN
         lock_active <= 1'b0;
         lock_id     <= '0;
`endif
      end else if (can_load) begin
         if (win_found) begin
            state    <= FULL;
            out_data <= req_data[win];
            out_id   <= win;
`ifdef PTYPE_RR_ARB_LOCK_EN
            if (lock_active) begin
               if (!req_lock[win]) begin
                  lock_active <= 1'b0;
                  rr_ptr      <= ptr_next;
               end
            end else if (req_lock[win]) begin
               lock_active <= 1'b1;
               lock_id     <= win;
            end else begin
               rr_ptr <= ptr_next;
            end
`else
            rr_ptr <= ptr_next;
`endif
         end else begin
            state <= EMPTY;
         end
      end
   end

endmodule

// File: tb/tb_ptype_rr_arb.sv
// Bench for ptype_rr_arb: directed scenarios plus random traffic, with a
// scoreboard of expected output beats drained by an independent monitor.
module tb_ptype_rr_arb;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req_valid;
   logic [N-1:0] req_ready;
   logic [N-1:0] lk;
   logic [7:0]   req_data [N];
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic [1:0]   out_id;

   logic [2:0]   v3;
   logic [2:0]   r3;
   logic [7:0]   d3 [3];
   logic         ov3;
   logic [7:0]   od3;
   logic [1:0]   oid3;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {logic [7:0] d; int id;} exp_t;
   exp_t sb[$];

   // reference model state
   bit m_full;
   int m_ptr;
   bit m_lock;
   int m_lock_id;

   always #5 clk = ~clk;

   ptype_rr_arb #(.NUM_REQ(N), .WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
`ifdef PTYPE_RR_ARB_LOCK_EN
      .req_lock(lk),
`endif
      .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
      .out_id(out_id), .out_ready(out_ready));

   ptype_rr_arb #(.NUM_REQ(3), .WIDTH(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_data(d3),
`ifdef PTYPE_RR_ARB_LOCK_EN
      .req_lock(3'b000),
`endif
      .req_ready(r3), .out_valid(ov3), .out_data(od3),
      .out_id(oid3), .out_ready(1'b1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int model_winner();
      int j;
      if (m_lock) return req_valid[m_lock_id] ? m_lock_id : -1;
      for (int k = 0; k < N; k++) begin
         j = (m_ptr + k) % N;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_full = 0; m_ptr = 0; m_lock = 0; m_lock_id = 0;
      sb.delete();
   endtask

   // Called at posedge+1 with inputs driven; checks, updates the model and
   // returns at the next posedge+1. g is the index the model granted (-1 none).
   task automatic cycle(output int g);
      int w;
      bit cl;
      logic [N-1:0] er;
      #1;
      w  = model_winner();
      cl = !m_full || out_ready;
      er = '0;
      if (cl && w >= 0) er = N'(1) << w;
      chk("out_valid", 32'(out_valid), 32'(m_full));
      chk("req_ready", 32'(req_ready), 32'(er));
      g = -1;
      if (cl) begin
         if (w >= 0) begin
            sb.push_back('{req_data[w], w});
            m_full = 1;
            g = w;
            if (m_lock) begin
               if (!lk[w]) begin m_lock = 0; m_ptr = (w + 1) % N; end
            end else if (lk[w]) begin
               m_lock = 1; m_lock_id = w;
            end else begin
               m_ptr = (w + 1) % N;
            end
         end else begin
            m_full = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: every delivered beat must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_empty: unexpected beat id %0d data %0h, expected none", out_id, out_data);
            end else begin
               e = sb.pop_front();
               chk("out_data", 32'(out_data), 32'(e.d));
               chk("out_id", 32'(out_id), 32'(e.id));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int seq4[6];
      int seq3[6];
      int lseq[5];
      seq4 = '{0, 1, 2, 3, 0, 1};
      seq3 = '{0, 1, 2, 0, 1, 2};
      lseq = '{1, 1, 1, 3, 0};
      req_valid = '0; lk = '0; out_ready = 1'b1; v3 = '0;
      for (int i = 0; i < N; i++) req_data[i] = '0;
      for (int i = 0; i < 3; i++) d3[i] = 8'h30 + 8'(i);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_id", 32'(out_id), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;

      // streaming from a single requester
      for (int k = 0; k < 8; k++) begin
         req_valid = 4'b0100;
         req_data[2] = 8'h10 + 8'(k);
         cycle(g);
      end
      req_valid = '0;
      cycle(g);
      cycle(g);

      // fairness from a fresh reset, 4 and 3 requesters
      do_reset();
      for (int i = 0; i < N; i++) req_data[i] = 8'hC0 + 8'(i);
      req_valid = 4'hF;
      v3 = 3'b111;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("fair4_ready", 32'(req_ready), 32'(4'(1) << seq4[k]));
         chk("fair3_ready", 32'(r3), 32'(3'(1) << seq3[k]));
         cycle(g);
      end
      v3 = '0;
      req_valid = '0;
      cycle(g);

      // backpressure holds the beat and the pointer
      req_valid = 4'b0001;
      req_data[0] = 8'hA5;
      cycle(g);
      out_ready = 1'b0;
      req_valid = 4'hF;
      for (int i = 0; i < N; i++) req_data[i] = 8'h60 + 8'(i);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_out_data", 32'(out_data), 32'hA5);
         cycle(g);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'b0010);
      cycle(g);

      // idle drain then immediate grant to index 1
      req_valid = '0;
      cycle(g);
      cycle(g);
      req_valid = 4'b0010;
      req_data[1] = 8'h77;
      #1;
      chk("idle_grant1", 32'(req_ready), 32'b0010);
      cycle(g);
      req_valid = '0;
      cycle(g);

      // asynchronous reset while a beat is held
      req_valid = 4'b1000;
      req_data[3] = 8'h3C;
      cycle(g);
      req_valid = 4'hF;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_id", 32'(out_id), 32'd0);
      chk("arst_req_ready", 32'(req_ready), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle(g);
      req_valid = '0;
      cycle(g);
      cycle(g);

`ifdef PTYPE_RR_ARB_LOCK_EN
      do_reset();
      req_valid = 4'b0001;
      req_data[0] = 8'h01;
      cycle(g);
      req_valid = 4'b1011;
      req_data[0] = 8'h02;
      req_data[3] = 8'h03;
      for (int k = 0; k < 5; k++) begin
         req_data[1] = 8'h51 + 8'(k);
         lk = (k < 2) ? 4'b0010 : 4'b0000;
         #1;
         chk("lock_seq", 32'(req_ready), 32'(4'(1) << lseq[k]));
         cycle(g);
         if (g >= 0 && k >= 2) req_valid[g] = 1'b0;
      end
      req_valid = 4'b1011;
      lk = 4'b0010;
      cycle(g);
      req_valid = 4'b1001;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("lock_idle_ready", 32'(req_ready), 32'd0);
         cycle(g);
      end
      req_valid = 4'b1011;
      lk = 4'b0000;
      cycle(g);
      req_valid = '0;
      cycle(g);
      cycle(g);
`endif

      // random traffic
      for (int c = 0; c < 400; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               req_valid[i] = 1'b1;
               req_data[i] = 8'($urandom);
`ifdef PTYPE_RR_ARB_LOCK_EN
               lk[i] = ($urandom_range(0, 3) == 0);
`endif
            end
         end
         cycle(g);
         if (g >= 0) req_valid[g] = 1'b0;
      end
      req_valid = '0;
      lk = '0;
      out_ready = 1'b1;
      cycle(g);
      cycle(g);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ptype_rr_arb.md
Name: ptype_rr_arb

Overview:
- Round-robin arbiter and single-entry output register that shares one typed datapath among NUM_REQ requesters.
- Payload type is a type parameter, so the same block carries user typedefs or plain packed vectors.
- Sits in front of a shared ptype_buf-style consumer; every requester uses a valid/ready handshake.
- The output carries the winning requester's index alongside the data.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16; need not be a power of 2.
- WIDTH, 8: width used by the default payload type.
- TYPE_T, logic [WIDTH-1:0]: payload type (type parameter).
- ID_W, $clog2(NUM_REQ): width of the out_id field (localparam).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NUM_REQ  per-requester valid.
- req_data  input  TYPE_T [NUM_REQ]  per-requester payload (unpacked array).
- req_ready  output  NUM_REQ  per-requester accept; zero-hot or one-hot.
- out_valid  output  1  output register holds a beat.
- out_data  output  TYPE_T  payload of the held beat.
- out_id  output  ID_W  index of the requester that supplied the held beat.
- out_ready  input  1  downstream accept.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, out_data='0, out_id=0, rr_ptr=0, state=EMPTY. req_ready is combinational and is all-zero while rst_n=0.
- State machine, 2 states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = (state==EMPTY) | (out_ready & out_valid).
- Winner selection: first index with req_valid set, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_REQ.
- req_ready[winner]=1 only when can_load=1 and a winner exists; all other bits are 0.
- Accept: on a req_valid[g] & req_ready[g] edge:
  - out_data<=req_data[g], out_id<=g, state<=FULL.
  - rr_ptr<=(g==NUM_REQ-1)?0:g+1. The wrap is explicit; it must not rely on power-of-2 overflow.
- Transitions:
  - EMPTY, any valid -> FULL.
  - EMPTY, none valid -> EMPTY.
  - FULL, out_ready=1, any valid -> FULL. Drain and load happen in the same cycle, giving 1 beat/cycle throughput.
  - FULL, out_ready=1, none valid -> EMPTY.
  - FULL, out_ready=0 -> FULL. out_data/out_id stay stable and all req_ready are 0.
- Latency: accepted beat appears on out_valid the next cycle.
- rr_ptr changes only on an accept, never on backpressure or idle cycles.
- Requester contract:
  - Hold req_valid/req_data until ready.
  - The arbiter never raises ready to a requester whose valid is 0.
  - A requester lowering valid before grant is tolerated; it simply loses the grant.
- Single requester: gets ready every cycle can_load=1. No starvation penalty.
- Fairness: with all requesters continuously valid, grant order is strictly cyclic. No requester waits more than NUM_REQ-1 accepts.
- Reset mid-operation: the held beat is discarded and out_valid drops asynchronously. The arbiter restarts at rr_ptr=0.

Optional Feature:
- Macro: PTYPE_RR_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock [NUM_REQ].
  - An accept with req_lock[g]=1 sets lock_active=1, lock_id=g.
  - While lock_active=1, only lock_id may receive ready, even if it is idle and others are valid.
  - An accept from lock_id with req_lock=0 clears the lock and advances rr_ptr normally.
  - rr_ptr stays frozen during a locked burst.
  - Reset clears lock_active.
- Undefined: no req_lock port, no lock state, pure round-robin.

Test Plan:
- Reset: rst_n=0 mid-transfer while out_valid=1 -> out_valid=0 and out_id=0 immediately; req_ready=0. After release, first grant searches from index 0.
- Streaming: only req 2 valid, out_ready=1, data 0x10..0x17 -> 8 consecutive outputs, 1/cycle, out_id=2, latency 1.
- Fairness: NUM_REQ=4, all valid, out_ready=1 -> out_id sequence 0,1,2,3,0,1. Repeat with NUM_REQ=3 and expect 0,1,2,0 (wrap check).
- Backpressure: FULL with out_data=0xA5, out_ready=0 for 3 cycles, all req valid -> out_data stays 0xA5, req_ready=0, rr_ptr unchanged. out_ready=1 -> drain and new load in the same cycle.
- Idle drain: FULL, out_ready=1, no valid -> EMPTY next cycle. A later single valid at index 1 is granted immediately.
- Lock (PTYPE_RR_ARB_LOCK_EN): req 1 sends 3 beats with lock=1,1,0 while reqs 0 and 3 are valid -> out_id 1,1,1, then 3, then 0. Req 1 idling mid-lock -> no grants to others.
